seq_bit_serializer: RTL and testbench

//   Parallel-to-serial source stage that feeds the sequence detector's serial 'in' input.

---
 rtl/seq_bit_serializer.sv | 123 ++++++++++++
 tb/tb_seq_bit_serializer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial source stage: accepts WIDTH-bit words over valid/ready and
// streams them one bit per clock, back-to-back words with no idle gap.
module seq_bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               data_valid,
  output logic               data_ready,
  output logic               out,
  output logic               bit_valid,
  output logic               busy,
  output logic               frame_done,
  output logic [COUNT_W-1:0] word_count,
  output logic               state_dbg
);

  // Handshake: a word transfers on a rising edge where data_valid && data_ready.
  // data_ready depends only on state and bit_cnt, never on data_valid, and the
  // upstream source must hold data_in stable until the transfer completes.

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   shreg_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   bit_cnt_nxt;
  logic               out_nxt;
  logic               bit_valid_nxt;
  logic               frame_done_nxt;
  logic [COUNT_W-1:0] word_count_nxt;
  logic               xfer;
  logic               last_bit;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  assign data_ready = (state == IDLE) || (bit_cnt == '0);
  assign xfer       = data_valid && data_ready;
  assign last_bit   = (state == SHIFT) && (bit_cnt == '0);
  assign busy       = (state == SHIFT);
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A new word arriving on the last-bit edge keeps us in SHIFT (gapless).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = SHIFT;
      SHIFT:   if ((bit_cnt == '0) && !xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shreg_nxt      = '0;
    bit_cnt_nxt    = '0;
    out_nxt        = IDLE_LEVEL;
    bit_valid_nxt  = 1'b0;
    frame_done_nxt = 1'b0;
    word_count_nxt = word_count;
    if (last_bit) begin
      word_count_nxt = word_count + 1'b1;
    end
    // The first bit goes straight to 'out'; the shifter keeps the remainder.
    if (xfer) begin
      out_nxt       = first_bit(data_in);
      shreg_nxt     = advance(data_in);
      bit_cnt_nxt   = CNT_LAST;
      bit_valid_nxt = 1'b1;
    end else if ((state == SHIFT) && (bit_cnt != '0)) begin
      out_nxt        = first_bit(shreg);
      shreg_nxt      = advance(shreg);
      bit_cnt_nxt    = bit_cnt - 1'b1;
      bit_valid_nxt  = 1'b1;
      frame_done_nxt = (bit_cnt == CNT_ONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      out        <= IDLE_LEVEL;
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
      word_count <= '0;
    end else begin
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      out        <= out_nxt;
      bit_valid  <= bit_valid_nxt;
      frame_done <= frame_done_nxt;
      word_count <= word_count_nxt;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: an MSB-first 16-bit-count instance and an
// LSB-first 4-bit-count instance, each checked against an expected-bit queue.
module tb_seq_bit_serializer;

  localparam logic [7:0] PAT = 8'b1111_1010;

  logic        clk;
  logic        reset;
  logic [7:0]  data_in0;
  logic        data_valid0;
  logic        data_ready0;
  logic        out0;
  logic        bit_valid0;
  logic        busy0;
  logic        frame_done0;
  logic [15:0] word_count0;
  logic        state_dbg0;
  logic [7:0]  data_in1;
  logic        data_valid1;
  logic        data_ready1;
  logic        out1;
  logic        bit_valid1;
  logic        busy1;
  logic        frame_done1;
  logic [3:0]  word_count1;
  logic        state_dbg1;

  logic [1:0]  exp_q0[$];
  logic [1:0]  exp_q1[$];
  logic [15:0] exp_wc0;
  logic [3:0]  exp_wc1;
  int          n_tests;
  int          n_fail;
  int          run0, max_run0, run1, max_run1;
  logic [7:0]  hist1;
  int          det_hits1;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0), .COUNT_W(16)) u0 (
    .clk(clk), .reset(reset), .data_in(data_in0), .data_valid(data_valid0),
    .data_ready(data_ready0), .out(out0), .bit_valid(bit_valid0), .busy(busy0),
    .frame_done(frame_done0), .word_count(word_count0), .state_dbg(state_dbg0)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0), .COUNT_W(4)) u1 (
    .clk(clk), .reset(reset), .data_in(data_in1), .data_valid(data_valid1),
    .data_ready(data_ready1), .out(out1), .bit_valid(bit_valid1), .busy(busy1),
    .frame_done(frame_done1), .word_count(word_count1), .state_dbg(state_dbg1)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver: call at a negedge; returns at the negedge after the transfer edge.
  task automatic drive(input int d, input logic [7:0] w);
    int guard;
    guard = 0;
    if (d == 0) begin
      data_in0 = w;
      data_valid0 = 1'b1;
      while (!data_ready0 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      for (int i = 7; i >= 0; i--) exp_q0.push_back({i == 0, w[i]});
    end else begin
      data_in1 = w;
      data_valid1 = 1'b1;
      while (!data_ready1 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      for (int i = 0; i < 8; i++) exp_q1.push_back({i == 7, w[i]});
    end
    if (guard >= 100) check("ready_timeout", 32'(0), 32'(1));
    @(negedge clk);
  endtask

  task automatic wait_idle(input int d);
    int guard;
    guard = 0;
    while (((d == 0) ? bit_valid0 : bit_valid1) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("idle_timeout", 32'(0), 32'(1));
  endtask

  // Reset pulse placed between edges; clears the bench's expectations too.
  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    exp_wc0 = '0;
    exp_wc1 = '0;
    #1;
    check("rst_out0", 32'(out0), 32'(0));
    check("rst_bv0", 32'(bit_valid0), 32'(0));
    check("rst_busy0", 32'(busy0), 32'(0));
    check("rst_ready0", 32'(data_ready0), 32'(1));
    check("rst_wc0", 32'(word_count0), 32'(0));
    check("rst_out1", 32'(out1), 32'(0));
    check("rst_wc1", 32'(word_count1), 32'(0));
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard
  always @(negedge clk) begin
    logic [1:0] e;
    if (!reset) begin
      if (bit_valid0) begin
        if (exp_q0.size() == 0) begin
          check("q0_underflow", 32'(1), 32'(0));
        end else begin
          e = exp_q0.pop_front();
          check("out0", 32'(out0), 32'(e[0]));
          check("fdone0", 32'(frame_done0), 32'(e[1]));
          check("ready0", 32'(data_ready0), 32'(e[1]));
          if (e[1]) begin
            check("wc0", 32'(word_count0), 32'(exp_wc0));
            exp_wc0 = exp_wc0 + 16'd1;
          end
        end
        run0++;
        if (run0 > max_run0) max_run0 = run0;
      end else begin
        check("idle_out0", 32'(out0), 32'(0));
        check("idle_fd0", 32'(frame_done0), 32'(0));
        run0 = 0;
      end
      if (bit_valid1) begin
        if (exp_q1.size() == 0) begin
          check("q1_underflow", 32'(1), 32'(0));
        end else begin
          e = exp_q1.pop_front();
          check("out1", 32'(out1), 32'(e[0]));
          check("fdone1", 32'(frame_done1), 32'(e[1]));
          if (e[1]) begin
            check("wc1", 32'(word_count1), 32'(exp_wc1));
            exp_wc1 = exp_wc1 + 4'd1;
          end
        end
        run1++;
        if (run1 > max_run1) max_run1 = run1;
      end else begin
        check("idle_out1", 32'(out1), 32'(0));
        run1 = 0;
      end
    end else begin
      run0 = 0;
      run1 = 0;
    end
  end

  // Sequence detector on the LSB-first serial stream
  always @(negedge clk) begin
    if (reset) begin
      hist1 = '0;
      det_hits1 = 0;
    end else if (bit_valid1) begin
      hist1 = {hist1[6:0], out1};
      if (hist1 == PAT) det_hits1++;
    end
  end

  initial begin
    logic [7:0] w;
    n_tests = 0;
    n_fail = 0;
    run0 = 0;
    run1 = 0;
    max_run0 = 0;
    max_run1 = 0;
    exp_wc0 = '0;
    exp_wc1 = '0;
    reset = 1'b1;
    data_in0 = '0;
    data_in1 = '0;
    data_valid0 = 1'b0;
    data_valid1 = 1'b0;
    #2;
    check("por_out0", 32'(out0), 32'(0));
    check("por_bv0", 32'(bit_valid0), 32'(0));
    check("por_busy0", 32'(busy0), 32'(0));
    check("por_ready0", 32'(data_ready0), 32'(1));
    check("por_wc0", 32'(word_count0), 32'(0));
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);

    // Reset during bit 3 of 8'hFF
    drive(0, 8'hFF);
    data_valid0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ff_bit3_valid", 32'(bit_valid0), 32'(1));
    pulse_reset();
    check("ff_wc_zero", 32'(word_count0), 32'(0));

    // First word after reset starts from its first bit
    drive(0, 8'h80);
    data_valid0 = 1'b0;
    check("x80_first", 32'(out0), 32'(1));
    wait_idle(0);
    check("x80_wc", 32'(word_count0), 32'(1));

    // Single word latency and frame_done placement
    max_run0 = 0;
    drive(0, 8'hB2);
    data_valid0 = 1'b0;
    check("b2_k1_out", 32'(out0), 32'(1));
    check("b2_k1_valid", 32'(bit_valid0), 32'(1));
    check("b2_k1_busy", 32'(busy0), 32'(1));
    check("b2_k1_fd", 32'(frame_done0), 32'(0));
    repeat (7) @(negedge clk);
    check("b2_k8_fd", 32'(frame_done0), 32'(1));
    check("b2_k8_out", 32'(out0), 32'(0));
    @(negedge clk);
    check("b2_k9_valid", 32'(bit_valid0), 32'(0));
    check("b2_k9_busy", 32'(busy0), 32'(0));
    check("b2_k9_wc", 32'(word_count0), 32'(2));
    check("b2_run", 32'(max_run0), 32'(8));

    // Two words back to back with data_valid held
    max_run0 = 0;
    drive(0, 8'hA5);
    drive(0, 8'h3C);
    data_valid0 = 1'b0;
    wait_idle(0);
    check("a53c_run", 32'(max_run0), 32'(16));
    check("a53c_wc", 32'(word_count0), 32'(4));

    // LSB-first single word
    drive(1, 8'h01);
    data_valid1 = 1'b0;
    check("x01_first", 32'(out1), 32'(1));
    wait_idle(1);
    check("x01_wc", 32'(word_count1), 32'(1));
    check("x01_idle", 32'(out1), 32'(0));

    // 16 gapless words: count wraps, detector sees a pattern across words 3/4
    pulse_reset();
    max_run1 = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) w = 8'hF0;
      else if (i == 4) w = 8'h05;
      else w = 8'($urandom_range(0, 255)) & 8'h55;
      drive(1, w);
    end
    data_valid1 = 1'b0;
    wait_idle(1);
    check("wrap_wc", 32'(word_count1), 32'(0));
    check("wrap_run", 32'(max_run1), 32'(128));
    check("det_hits", 32'(det_hits1), 32'(1));

    check("q0_empty", 32'(exp_q0.size()), 32'(0));
    check("q1_empty", 32'(exp_q1.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
